// File: rtl/coef_mul_feeder_pkg.sv
// Shared Kyber parameters and the packed payload types carried by the
// coefficient multiplier feeder pipeline.
package coef_mul_feeder_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int COEF_W  = 12;
    localparam int PROD_W  = 24;
    localparam int IDX_W   = 8;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [IDX_W-1:0]  idx_t;

    // Payload held in the operand stage.
    typedef struct packed {
        idx_t  idx;
        coef_t a;
        coef_t b;
    } s1_t;

    // Payload held in the product stage.
    typedef struct packed {
        logic  last;
        idx_t  idx;
        prod_t prod;
    } s2_t;

    // Exact unreduced product; 4095*4095 still fits in PROD_W bits.
    function automatic prod_t coef_mul(input coef_t a, input coef_t b);
        return prod_t'(a) * prod_t'(b);
    endfunction

endpackage

// File: rtl/coef_mul_feeder_pipe_stage_reg.sv
// One valid/ready register slice. An empty slice always accepts, so bubbles
// collapse; a full slice accepts only when its content leaves this cycle.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Next-state: load when this slice advances, otherwise hold.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    // Slice register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset too, because the block outputs must read zero while in reset.
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/coef_mul_feeder.sv
// Feeds coefficient pairs through a two-slice pipeline: operands plus index
// in S1, the full unreduced product plus index/last in S2, ready for the
// q=3329 reduction unit downstream.
module coef_mul_feeder
    import coef_mul_feeder_pkg::*;
#(
    parameter int Q = KYBER_Q,
    parameter int N = KYBER_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COEF_W-1:0] in_a,
    input  logic [COEF_W-1:0] in_b,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PROD_W-1:0] out_c,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              range_err
);

    localparam idx_t              LAST_IDX = IDX_W'(N - 1);
    localparam logic [COEF_W:0]   Q_EXT    = (COEF_W + 1)'(Q);

    s1_t  s1_in, s1_out;
    s2_t  s2_in, s2_out;
    logic s1_ready, s1_valid, s2_ready;
    logic in_fire;

    idx_t idx_q, idx_d;
    logic range_err_q, range_err_d;

    // Nothing is accepted while reset is held.
    assign in_ready = s1_ready && !rst;
    assign in_fire  = in_valid && in_ready;

    assign s1_in = '{idx: idx_q, a: in_a, b: in_b};

    pipe_stage_reg #(.W($bits(s1_t))) u_s1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (s1_ready),
        .in_data_i   (s1_in),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .out_data_o  (s1_out)
    );

    // Multiplier sits between the two slices.
    assign s2_in = '{last: (s1_out.idx == LAST_IDX),
                     idx:  s1_out.idx,
                     prod: coef_mul(s1_out.a, s1_out.b)};

    pipe_stage_reg #(.W($bits(s2_t))) u_s2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .in_data_i   (s2_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (s2_out)
    );

    assign out_c     = s2_out.prod;
    assign out_idx   = s2_out.idx;
    assign out_last  = s2_out.last;
    assign range_err = range_err_q;

    // Index counter wraps at N-1; range flag is sticky until reset.
    always_comb begin
        idx_d       = idx_q;
        range_err_d = range_err_q;
        if (in_fire) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            if (({1'b0, in_a} >= Q_EXT) || ({1'b0, in_b} >= Q_EXT)) begin
                range_err_d = 1'b1;
            end
        end
    end

    // Index counter and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            range_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            range_err_q <= range_err_d;
        end
    end

endmodule

// File: tb/tb_coef_mul_feeder.sv
// Self-checking bench for coef_mul_feeder: a negedge monitor pushes expected
// results on every input transfer and pops/compares on every output transfer;
// scenario tasks add targeted checks on latency, back-pressure and reset.
module tb_coef_mul_feeder;
    import coef_mul_feeder_pkg::*;

    typedef struct {
        logic [23:0] c;
        logic [7:0]  idx;
        logic        last;
    } sb_item_t;

    logic        clk;
    logic        rst;
    logic [11:0] in_a, in_b;
    logic        in_valid, in_ready;
    logic [23:0] out_c;
    logic [7:0]  out_idx;
    logic        out_last, out_valid, out_ready, range_err;

    int vectors     = 0;
    int miscompares = 0;
    int last_seen   = 0;

    sb_item_t    sb[$];
    sb_item_t    exp_item;
    logic [7:0]  model_idx = 8'd0;

    coef_mul_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_c     (out_c),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: inputs change at posedge+1, so negedge sees the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            model_idx = 8'd0;
        end else begin
            if (out_valid && out_ready) begin
                vectors++;
                if (out_last) last_seen++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_stale: unexpected output c=%0d idx=%0d, expected none", out_c, out_idx);
                end else begin
                    exp_item = sb.pop_front();
                    if (out_c !== exp_item.c || out_idx !== exp_item.idx || out_last !== exp_item.last) begin
                        miscompares++;
                        $display("FAIL sb_out: got c=%0d idx=%0d last=%0b, expected c=%0d idx=%0d last=%0b",
                                 out_c, out_idx, out_last, exp_item.c, exp_item.idx, exp_item.last);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{c: 24'(in_a) * 24'(in_b), idx: model_idx, last: (model_idx == 8'd255)});
                model_idx++;
            end
        end
    end

    // Leaves the bench at posedge+1 with rst low after one reset edge.
    task automatic apply_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Offers one pair and returns at posedge+1 right after it is accepted.
    task automatic send(input logic [11:0] a, input logic [11:0] b, output int waited);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, waited);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cnt = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        do begin
            @(negedge clk); #1;
            cnt++;
        end while ((sb.size() != 0 || out_valid) && cnt < 100);
        vectors++;
        if (sb.size() != 0 || out_valid) begin
            miscompares++;
            $display("FAIL drain: %0d items still pending, expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_c !== 24'd0 || out_idx !== 8'd0 ||
            out_last !== 1'b0 || range_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%0b rdy=%0b c=%0d idx=%0d last=%0b err=%0b, expected all 0",
                     out_valid, in_ready, out_c, out_idx, out_last, range_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got rdy=%0b v=%0b, expected rdy=1 v=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        apply_reset();
        out_ready = 1'b1;
        in_a      = 12'd3328;
        in_b      = 12'd3328;
        in_valid  = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL lat_accept: in_ready=%0b, expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_early: out_valid=%0b one cycle after accept, expected 0", out_valid);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_c !== 24'hA90000 || out_idx !== 8'd0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_out: got v=%0b c=%0h idx=%0d last=%0b, expected v=1 c=a90000 idx=0 last=0",
                     out_valid, out_c, out_idx, out_last);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_dup: out_valid=%0b after transfer, expected 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int waited;
        int last_before;
        apply_reset();
        out_ready   = 1'b1;
        last_before = last_seen;
        for (int i = 0; i < 257; i++) begin
            send(12'(i), 12'd1, waited);
            vectors++;
            if (waited !== 0) begin
                miscompares++;
                $display("FAIL b2b_stall: item %0d waited %0d cycles, expected 0", i, waited);
            end
        end
        drain();
        vectors++;
        if (last_seen - last_before !== 1) begin
            miscompares++;
            $display("FAIL b2b_last: out_last seen %0d times, expected 1", last_seen - last_before);
        end
    endtask

    task automatic test_backpressure();
        int          k;
        logic        accepted;
        logic [23:0] held_c;
        logic [7:0]  held_idx;
        k         = 0;
        out_ready = 1'b0;
        in_a      = 12'd100;
        in_b      = 12'd7;
        in_valid  = 1'b1;
        held_c    = '0;
        held_idx  = '0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== (cyc < 2)) begin
                miscompares++;
                $display("FAIL bp_ready: cycle %0d in_ready=%0b, expected %0b", cyc, in_ready, (cyc < 2));
            end
            if (cyc == 2) begin
                held_c   = out_c;
                held_idx = out_idx;
                vectors++;
                if (out_valid !== 1'b1 || out_c !== 24'd700) begin
                    miscompares++;
                    $display("FAIL bp_head: got v=%0b c=%0d, expected v=1 c=700", out_valid, out_c);
                end
            end else if (cyc > 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out_c !== held_c || out_idx !== held_idx) begin
                    miscompares++;
                    $display("FAIL bp_stable: got v=%0b c=%0d idx=%0d, expected v=1 c=%0d idx=%0d",
                             out_valid, out_c, out_idx, held_c, held_idx);
                end
            end
            accepted = in_ready;
            @(posedge clk); #1;
            if (accepted) begin
                k++;
                in_a = 12'(100 + k);
            end
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_gap: release cycle %0d out_valid=%0b, expected 1", cyc, out_valid);
            end
            accepted = in_ready;
            @(posedge clk); #1;
            if (accepted && in_valid) begin
                k++;
                if (k == 5) in_valid = 1'b0;
                else        in_a = 12'(100 + k);
            end
        end
        drain();
    endtask

    task automatic test_range_err();
        int waited;
        apply_reset();
        out_ready = 1'b1;
        send(12'd3329, 12'd5, waited);
        @(negedge clk);
        vectors++;
        if (range_err !== 1'b1) begin
            miscompares++;
            $display("FAIL range_set: range_err=%0b, expected 1", range_err);
        end
        @(posedge clk); #1;
        send(12'd5, 12'd5, waited);
        send(12'd3328, 12'd1, waited);
        send(12'd0, 12'd3328, waited);
        drain();
        vectors++;
        if (range_err !== 1'b1) begin
            miscompares++;
            $display("FAIL range_sticky: range_err=%0b, expected 1", range_err);
        end
        send(12'd1, 12'd3329, waited);
        drain();
        apply_reset();
        @(negedge clk);
        vectors++;
        if (range_err !== 1'b0) begin
            miscompares++;
            $display("FAIL range_clear: range_err=%0b, expected 0", range_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        int waited;
        out_ready = 1'b0;
        send(12'd11, 12'd2, waited);
        send(12'd12, 12'd3, waited);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_full: got v=%0b rdy=%0b, expected v=1 rdy=0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_flush: got v=%0b rdy=%0b, expected v=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        send(12'd20, 12'd4, waited);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 8'd0 || out_c !== 24'd80) begin
            miscompares++;
            $display("FAIL mid_restart: got v=%0b idx=%0d c=%0d, expected v=1 idx=0 c=80",
                     out_valid, out_idx, out_c);
        end
        @(posedge clk); #1;
        drain();
    endtask

    initial begin
        rst       = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_range_err();
        test_reset_midflight();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL final_sb: %0d items left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
